// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
package display_pkg;
    localparam int SEG_W              = 7;
    localparam int DIGIT_W            = 4;
    localparam int DEFAULT_NUM_DIGITS = 4;
    localparam int MAX_DIGITS         = 32;

    // Anodes are active-low, so "all off" is all ones; callers size-cast to their digit count.
    function automatic logic [MAX_DIGITS-1:0] an_off();
        return '1;
    endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// Digit-slot timer: counts REFRESH_DIV cycles per slot and flags the anode dead window.
module refresh_prescaler #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,
    output logic dead_next
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // dead_next describes the cycle after the coming edge so the parent can register its anodes.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
        dead_next = (cnt_d < DEAD_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with frame-aligned loads,
// leading-zero blanking and anode dead-time.
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic                          load,
    input  logic                          blank_lz,
    output logic [3:0]                    nibble,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = DIGIT_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = NUM_DIGITS'(an_off());

    logic                  slot_end;
    logic                  dead_next;
    logic                  wrap;
    logic                  blanked;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      active_q, active_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [DIGIT_W-1:0]    nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;
    logic [DIGIT_W-1:0]    digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lead_zero;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_end  (slot_end),
        .dead_next (dead_next)
    );

    always_comb begin
        wrap         = slot_end && (idx_q == IDX_LAST);
        idx_d        = idx_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_done_d = wrap;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        // A load on the wrap edge bypasses the shadow so it shows in the very next slot.
        if (wrap) begin
            if (load || pending_q) begin
                active_d = load ? value : shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    // Digit i is a leading zero when every nibble from the top down to i is zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digits[gi]    = active_d[DIGIT_W*gi +: DIGIT_W];
            assign lead_zero[gi] = (active_d[VAL_W-1:DIGIT_W*gi] == '0);
        end
    endgenerate

    // Outputs are computed from next state so they land together with the new slot.
    always_comb begin
        nibble_d = digits[idx_d];
        blanked  = blank_lz && (idx_d != '0) && lead_zero[idx_d];
        an_d     = AN_ALL_OFF;
        if (!dead_next && !blanked) begin
            an_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= '0;
            an_q         <= AN_ALL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nibble     = nibble_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: a time-based scan model checked every cycle plus directed literal checks.
module tb_display_scanner;
    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int DEAD  = 1;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Model state: cycles since reset release and the value the current frame shows.
    int          m_t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pend = 1'b0;

    display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .nibble     (nibble),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0d)", name, act, exp_v, m_t);
        end
    endtask

    // Expected outputs derived from the scan timeline: slot = t/DIV, position in slot = t%DIV.
    always @(posedge clk) begin
        logic        s_load;
        logic [15:0] s_value;
        logic        s_blank;
        int          idx, cnt;
        logic [15:0] upper;
        logic [3:0]  e_an;
        s_load  = load;
        s_value = value;
        s_blank = blank_lz;
        if (!rst_n) begin
            m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                if (s_load)      m_disp = s_value;
                else if (m_pend) m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (s_load) begin
                m_shadow = s_value;
                m_pend   = 1'b1;
            end
        end
        idx   = (m_t / DIV) % N;
        cnt   = m_t % DIV;
        upper = m_disp >> (4 * idx);
        e_an  = 4'hF;
        if (cnt >= DEAD && !(s_blank && idx > 0 && upper == 16'h0))
            e_an[idx] = 1'b0;
        #1;
        check("m_nibble", 32'(nibble), 32'(upper[3:0]));
        check("m_an", 32'(an), 32'(e_an));
        check("m_idx", 32'(digit_idx), 32'(idx));
        check("m_frame_done", 32'(frame_done), 32'((m_t > 0) && (m_t % FRAME == 0)));
    end

    // Advance to the next negedge whose scan phase (t mod frame) equals p.
    task automatic goto(input int p);
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk);
            if (m_t % FRAME == p) return;
        end
        total++;
        bad++;
        $display("FAIL goto_timeout: phase %0d not reached, now %0d", p, m_t % FRAME);
    endtask

    task automatic do_load(input logic [15:0] v);
        $display("load value=%h at phase %0d", v, (m_t + 1) % FRAME);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        // 1: reset state and free-running scan
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_nibble", 32'(nibble), 32'h0);
        check("rst_idx", 32'(digit_idx), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        goto(0);
        check("t1_fd", 32'(frame_done), 32'h1);
        goto(1);
        check("t1_fd_low", 32'(frame_done), 32'h0);
        check("t1_an", 32'(an), 32'hE);

        // 2: mid-frame load of 1234 appears next frame
        goto(5);
        do_load(16'h1234);
        goto(0);
        check("t2_dead_an", 32'(an), 32'hF);
        check("t2_dead_nib", 32'(nibble), 32'h4);
        goto(1);
        check("t2_d0_nib", 32'(nibble), 32'h4);
        check("t2_d0_an", 32'(an), 32'hE);
        goto(13);
        check("t2_d3_nib", 32'(nibble), 32'h1);
        check("t2_d3_an", 32'(an), 32'h7);

        // 3: leading-zero blanking
        blank_lz = 1'b1;
        goto(15);
        do_load(16'h0050);
        goto(1);
        check("t3_d0_an", 32'(an), 32'hE);
        goto(5);
        check("t3_d1_an", 32'(an), 32'hD);
        check("t3_d1_nib", 32'(nibble), 32'h5);
        goto(9);
        check("t3_d2_an", 32'(an), 32'hF);
        goto(13);
        check("t3_d3_an", 32'(an), 32'hF);
        goto(15);
        do_load(16'h0000);
        goto(1);
        check("t3_z_d0_an", 32'(an), 32'hE);
        goto(5);
        check("t3_z_d1_an", 32'(an), 32'hF);
        blank_lz = 1'b0;
        goto(9);
        check("t3_nb_d2_an", 32'(an), 32'hB);
        goto(13);
        check("t3_nb_d3_an", 32'(an), 32'h7);

        // 4: mid-frame loads wait for the boundary; last one wins
        goto(15);
        do_load(16'h1234);
        goto(4);
        do_load(16'hABCD);
        goto(9);
        check("t4_old_nib", 32'(nibble), 32'h2);
        goto(1);
        check("t4_new_nib", 32'(nibble), 32'hD);
        goto(5);
        do_load(16'h1111);
        goto(8);
        do_load(16'h2222);
        goto(13);
        check("t4_hold_nib", 32'(nibble), 32'hA);
        goto(13);
        check("t4_last_nib", 32'(nibble), 32'h2);

        // 5: load on the boundary edge takes effect immediately, no stale pending
        goto(15);
        do_load(16'h5678);
        goto(1);
        check("t5_nib", 32'(nibble), 32'h8);
        goto(1);
        check("t5_next_nib", 32'(nibble), 32'h8);

        // 6: async reset in digit-2 slot
        goto(9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_an", 32'(an), 32'hF);
        check("t6_idx", 32'(digit_idx), 32'h0);
        check("t6_nib", 32'(nibble), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        goto(1);
        check("t6_re_nib", 32'(nibble), 32'h0);
        check("t6_re_an", 32'(an), 32'hE);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
